// File: rtl/program_memory_loader.sv
// Loads a byte-streamed program image into instruction memory as 32-bit words
// (MSB byte first) and shares the memory address port with the CPU fetch path.
module program_memory_loader #(
  parameter int unsigned MEMORY_DEPTH = 256,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH:0]   word_count_i,
  input  logic [7:0]            byte_i,
  input  logic                  byte_valid_i,
  output logic                  byte_ready_o,
  input  logic [DATA_WIDTH-1:0] cpu_address_i,
  output logic [ADDR_WIDTH-1:0] mem_address_o,
  output logic [DATA_WIDTH-1:0] mem_data_o,
  output logic                  mem_we_o,
  output logic                  cpu_hold_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  error_o,
  output logic                  misaligned_o
);

  localparam int unsigned CW = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

  state_t                state_q, state_d;
  logic [1:0]            byte_cnt_q, byte_cnt_d;
  logic [CW-1:0]         word_addr_q, word_addr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [DATA_WIDTH-1:0] asm_q, asm_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] shifted;
  logic [CW-1:0]         addr_inc;

  // PC bits above the memory word range do not select anything
  logic unused_cpu_bits;
  assign unused_cpu_bits = ^cpu_address_i[DATA_WIDTH-1:ADDR_WIDTH+2];

  assign shifted  = {asm_q[DATA_WIDTH-9:0], byte_i};
  assign addr_inc = word_addr_q + CW'(1);

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      byte_cnt_q  <= 2'd0;
      word_addr_q <= '0;
      count_q     <= '0;
      asm_q       <= '0;
      data_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      word_addr_q <= word_addr_d;
      count_q     <= count_d;
      asm_q       <= asm_d;
      data_q      <= data_d;
      err_q       <= err_d;
    end
  end

  // Next-state and state-decoded outputs
  always_comb begin
    state_d       = state_q;
    byte_cnt_d    = byte_cnt_q;
    word_addr_d   = word_addr_q;
    count_d       = count_q;
    asm_d         = asm_q;
    data_d        = data_q;
    err_d         = err_q;
    byte_ready_o  = 1'b0;
    mem_we_o      = 1'b0;
    cpu_hold_o    = 1'b0;
    busy_o        = 1'b0;
    done_o        = 1'b0;
    mem_address_o = cpu_address_i[ADDR_WIDTH+1:2];

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          if (word_count_i == '0) begin
            err_d   = 1'b0;
            state_d = DONE;
          end else if (word_count_i > CW'(MEMORY_DEPTH)) begin
            err_d = 1'b1;
          end else begin
            err_d       = 1'b0;
            count_d     = word_count_i;
            word_addr_d = '0;
            byte_cnt_d  = 2'd0;
            state_d     = RECV;
          end
        end
      end
      RECV: begin
        byte_ready_o  = 1'b1;
        cpu_hold_o    = 1'b1;
        busy_o        = 1'b1;
        mem_address_o = word_addr_q[ADDR_WIDTH-1:0];
        if (byte_valid_i) begin
          asm_d      = shifted;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            data_d  = shifted;
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        mem_we_o      = 1'b1;
        cpu_hold_o    = 1'b1;
        busy_o        = 1'b1;
        mem_address_o = word_addr_q[ADDR_WIDTH-1:0];
        word_addr_d   = addr_inc;
        byte_cnt_d    = 2'd0;
        state_d       = (addr_inc == count_q) ? DONE : RECV;
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_data_o   = data_q;
  assign error_o      = err_q;
  assign misaligned_o = (cpu_address_i[1:0] != 2'b00) && !busy_o;

endmodule

// File: tb/tb_program_memory_loader.sv
// Directed self-checking bench for program_memory_loader.
module tb_program_memory_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_i;
  logic [8:0]  word_count_i;
  logic [7:0]  byte_i;
  logic        byte_valid_i;
  logic        byte_ready_o;
  logic [31:0] cpu_address_i;
  logic [7:0]  mem_address_o;
  logic [31:0] mem_data_o;
  logic        mem_we_o;
  logic        cpu_hold_o;
  logic        busy_o;
  logic        done_o;
  logic        error_o;
  logic        misaligned_o;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int start_cyc = 0;

  logic [7:0]  wr_addr[$];
  logic [31:0] wr_data[$];
  int          wr_cyc[$];
  int          done_cnt = 0;
  int          done_cyc = 0;
  int          hold_cnt = 0;

  program_memory_loader dut (
    .clk(clk), .reset(reset), .start_i(start_i), .word_count_i(word_count_i),
    .byte_i(byte_i), .byte_valid_i(byte_valid_i), .byte_ready_o(byte_ready_o),
    .cpu_address_i(cpu_address_i), .mem_address_o(mem_address_o),
    .mem_data_o(mem_data_o), .mem_we_o(mem_we_o), .cpu_hold_o(cpu_hold_o),
    .busy_o(busy_o), .done_o(done_o), .error_o(error_o),
    .misaligned_o(misaligned_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  // Log memory writes, done pulses and hold cycles, sampled mid low phase
  always @(negedge clk) begin
    #1;
    if (mem_we_o) begin
      wr_addr.push_back(mem_address_o);
      wr_data.push_back(mem_data_o);
      wr_cyc.push_back(cyc);
    end
    if (done_o) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
    if (cpu_hold_o) hold_cnt = hold_cnt + 1;
  end

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
    done_cnt = 0;
    hold_cnt = 0;
  endtask

  // Called at a falling edge; returns at the falling edge after the start edge
  task automatic do_start(input logic [8:0] cnt);
    start_i      = 1'b1;
    word_count_i = cnt;
    @(negedge clk);
    start_i   = 1'b0;
    start_cyc = cyc;
  endtask

  // Presents one byte until accepted; returns at the following falling edge
  task automatic push_byte(input logic [7:0] b);
    bit got = 1'b0;
    byte_i       = b;
    byte_valid_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (byte_ready_o) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL byte_accept: byte %02h not accepted within 20 cycles, required acceptance", b);
    end else begin
      @(posedge clk);
      @(negedge clk);
    end
    byte_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; start_i = 1'b0; word_count_i = '0; byte_i = '0;
    byte_valid_i = 1'b0; cpu_address_i = 32'h0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({byte_ready_o, mem_we_o, cpu_hold_o, busy_o, done_o, error_o} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b required 000000",
               {byte_ready_o, mem_we_o, cpu_hold_o, busy_o, done_o, error_o});
    end
    checks++;
    if (mem_data_o !== 32'h0) begin
      errors++; $display("FAIL reset_data: got %h required 00000000", mem_data_o);
    end
    @(negedge clk);
    reset = 1'b1;
    cpu_address_i = 32'h0000_0010;
    #1;
    checks++;
    if (mem_address_o !== 8'd4) begin
      errors++; $display("FAIL idle_addr: got %0d required 4", mem_address_o);
    end
    checks++;
    if ({mem_we_o, cpu_hold_o, misaligned_o} !== 3'b000) begin
      errors++; $display("FAIL idle_flags: we/hold/mis got %b required 000",
                         {mem_we_o, cpu_hold_o, misaligned_o});
    end
    @(negedge clk);
  endtask

  task automatic test_load2();
    clear_log();
    do_start(9'd2);
    #1;
    checks++;
    if ({cpu_hold_o, busy_o, byte_ready_o} !== 3'b111) begin
      errors++; $display("FAIL load_hold_after_start: got %b required 111",
                         {cpu_hold_o, busy_o, byte_ready_o});
    end
    push_byte(8'h20); push_byte(8'h08); push_byte(8'h00); push_byte(8'h05);
    push_byte(8'h00); push_byte(8'h00); push_byte(8'h00); push_byte(8'h08);
    repeat (3) @(negedge clk);
    #2;
    checks++;
    if (wr_addr.size() != 2) begin
      errors++; $display("FAIL load_nwrites: got %0d required 2", wr_addr.size());
    end else begin
      checks++;
      if (wr_addr[0] !== 8'd0 || wr_data[0] !== 32'h2008_0005) begin
        errors++; $display("FAIL load_w0: got %0d/%h required 0/20080005", wr_addr[0], wr_data[0]);
      end
      checks++;
      if (wr_addr[1] !== 8'd1 || wr_data[1] !== 32'h0000_0008) begin
        errors++; $display("FAIL load_w1: got %0d/%h required 1/00000008", wr_addr[1], wr_data[1]);
      end
      checks++;
      if (wr_cyc[0] - start_cyc != 4 || wr_cyc[1] - start_cyc != 9) begin
        errors++; $display("FAIL load_timing: got +%0d/+%0d required +4/+9",
                           wr_cyc[0] - start_cyc, wr_cyc[1] - start_cyc);
      end
    end
    checks++;
    if (done_cnt != 1 || done_cyc - start_cyc != 10) begin
      errors++; $display("FAIL load_done: got %0d pulses at +%0d required 1 at +10",
                         done_cnt, done_cyc - start_cyc);
    end
    checks++;
    if (hold_cnt != 10) begin
      errors++; $display("FAIL load_hold_cycles: got %0d required 10", hold_cnt);
    end
  endtask

  task automatic test_stall();
    clear_log();
    do_start(9'd2);
    push_byte(8'h20); push_byte(8'h08);
    repeat (3) @(negedge clk);
    push_byte(8'h00); push_byte(8'h05);
    push_byte(8'h00); push_byte(8'h00); push_byte(8'h00); push_byte(8'h08);
    repeat (3) @(negedge clk);
    #2;
    checks++;
    if (wr_addr.size() != 2) begin
      errors++; $display("FAIL stall_nwrites: got %0d required 2", wr_addr.size());
    end else begin
      checks++;
      if (wr_data[0] !== 32'h2008_0005 || wr_data[1] !== 32'h0000_0008 ||
          wr_addr[0] !== 8'd0 || wr_addr[1] !== 8'd1) begin
        errors++; $display("FAIL stall_data: got %0d/%h %0d/%h required 0/20080005 1/00000008",
                           wr_addr[0], wr_data[0], wr_addr[1], wr_data[1]);
      end
      checks++;
      if (wr_cyc[0] - start_cyc != 7 || wr_cyc[1] - start_cyc != 12) begin
        errors++; $display("FAIL stall_timing: got +%0d/+%0d required +7/+12",
                           wr_cyc[0] - start_cyc, wr_cyc[1] - start_cyc);
      end
    end
    checks++;
    if (done_cnt != 1 || done_cyc - start_cyc != 13 || hold_cnt != 13) begin
      errors++; $display("FAIL stall_done: got %0d pulses at +%0d hold %0d required 1 at +13 hold 13",
                         done_cnt, done_cyc - start_cyc, hold_cnt);
    end
  endtask

  task automatic test_error();
    clear_log();
    do_start(9'd300);
    #1;
    checks++;
    if ({error_o, busy_o, cpu_hold_o, byte_ready_o} !== 4'b1000) begin
      errors++; $display("FAIL err_set: err/busy/hold/rdy got %b required 1000",
                         {error_o, busy_o, cpu_hold_o, byte_ready_o});
    end
    checks++;
    if (mem_data_o !== 32'h0000_0008) begin
      errors++; $display("FAIL err_data_hold: got %h required 00000008", mem_data_o);
    end
    @(negedge clk);
    #1;
    checks++;
    if (error_o !== 1'b1 || wr_addr.size() != 0) begin
      errors++; $display("FAIL err_sticky: err %b writes %0d required 1 and 0", error_o, wr_addr.size());
    end
    @(negedge clk);
    do_start(9'd0);
    #1;
    checks++;
    if (done_o !== 1'b1 || error_o !== 1'b0) begin
      errors++; $display("FAIL zero_count: done/err got %b%b required 10", done_o, error_o);
    end
    @(negedge clk);
    #1;
    checks++;
    if (done_o !== 1'b0 || wr_addr.size() != 0) begin
      errors++; $display("FAIL zero_count_end: done %b writes %0d required 0 and 0", done_o, wr_addr.size());
    end
  endtask

  task automatic test_reset_midload();
    clear_log();
    do_start(9'd3);
    push_byte(8'h01); push_byte(8'h02); push_byte(8'h03); push_byte(8'h04);
    push_byte(8'h05); push_byte(8'h06);
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({byte_ready_o, mem_we_o, cpu_hold_o, busy_o, done_o, error_o} !== 6'b0 ||
        mem_data_o !== 32'h0) begin
      errors++; $display("FAIL async_reset: ctrl %b data %h required 000000 00000000",
                         {byte_ready_o, mem_we_o, cpu_hold_o, busy_o, done_o, error_o}, mem_data_o);
    end
    checks++;
    if (mem_address_o !== 8'd4) begin
      errors++; $display("FAIL async_reset_addr: got %0d required 4", mem_address_o);
    end
    checks++;
    if (wr_addr.size() != 1 || wr_data[0] !== 32'h0102_0304) begin
      errors++; $display("FAIL pre_reset_write: got %0d writes required 1 of 01020304", wr_addr.size());
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    clear_log();
    do_start(9'd1);
    push_byte(8'hCA); push_byte(8'hFE); push_byte(8'hBA); push_byte(8'hBE);
    repeat (3) @(negedge clk);
    #2;
    checks++;
    if (wr_addr.size() != 1 || done_cnt != 1) begin
      errors++; $display("FAIL reload_count: writes %0d done %0d required 1 and 1", wr_addr.size(), done_cnt);
    end else begin
      checks++;
      if (wr_addr[0] !== 8'd0 || wr_data[0] !== 32'hCAFE_BABE) begin
        errors++; $display("FAIL reload_w0: got %0d/%h required 0/cafebabe", wr_addr[0], wr_data[0]);
      end
    end
  endtask

  task automatic test_ignored_start();
    clear_log();
    do_start(9'd2);
    push_byte(8'h11); push_byte(8'h22);
    start_i = 1'b1; word_count_i = 9'd1;
    @(negedge clk);
    start_i = 1'b0;
    cpu_address_i = 32'h0000_0006;
    #1;
    checks++;
    if (misaligned_o !== 1'b0 || mem_address_o !== 8'd0 || busy_o !== 1'b1) begin
      errors++; $display("FAIL busy_mask: mis/addr/busy got %b/%0d/%b required 0/0/1",
                         misaligned_o, mem_address_o, busy_o);
    end
    push_byte(8'h33); push_byte(8'h44);
    push_byte(8'h55); push_byte(8'h66); push_byte(8'h77); push_byte(8'h88);
    repeat (3) @(negedge clk);
    #2;
    checks++;
    if (wr_addr.size() != 2 || done_cnt != 1) begin
      errors++; $display("FAIL ign_count: writes %0d done %0d required 2 and 1", wr_addr.size(), done_cnt);
    end else begin
      checks++;
      if (wr_addr[0] !== 8'd0 || wr_data[0] !== 32'h1122_3344 ||
          wr_addr[1] !== 8'd1 || wr_data[1] !== 32'h5566_7788) begin
        errors++; $display("FAIL ign_data: got %0d/%h %0d/%h required 0/11223344 1/55667788",
                           wr_addr[0], wr_data[0], wr_addr[1], wr_data[1]);
      end
    end
    checks++;
    if (misaligned_o !== 1'b1 || mem_address_o !== 8'd1) begin
      errors++; $display("FAIL misaligned_idle: mis/addr got %b/%0d required 1/1",
                         misaligned_o, mem_address_o);
    end
    cpu_address_i = 32'h0000_0010;
  endtask

  initial begin
    test_reset();
    test_load2();
    test_stall();
    test_error();
    test_reset_midload();
    test_ignored_start();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
